// File: rtl/chunked_adder_sub.sv
// chunked_adder_sub: multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock.
// Carry is held in a register between chunks; start/busy/done handshake.
module chunked_adder_sub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
    $error("chunked_adder_sub: WIDTH must be a multiple of CHUNK, 1<=CHUNK<=WIDTH");
  end

  state_t           r_state;
  state_t           w_next;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH:0]   r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_accept;
  logic             w_last;
  int               w_lo;
  logic [CHUNK:0]   w_csum;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;

  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_idx == IW'(NCHUNK - 1));

  // One chunk of the ripple sum plus the result with that chunk merged in
  always_comb begin
    w_lo   = int'(r_idx) * CHUNK;
    w_csum = {1'b0, r_a[w_lo +: CHUNK]}
           + {1'b0, r_b[w_lo +: CHUNK]}
           + {{CHUNK{1'b0}}, r_carry};
    w_res  = r_res;
    w_res[w_lo +: CHUNK] = w_csum[CHUNK-1:0];
    w_ovf  = (r_a[WIDTH-1] == r_b[WIDTH-1])
          && (w_res[WIDTH-1] != r_a[WIDTH-1]);
  end

  // Next-state logic for IDLE -> RUN -> DONE
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Operand capture, per-chunk accumulation and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= '0;
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? ~cin : cin;
    end else if (r_state == S_RUN) begin
      r_res   <= w_res;
      r_carry <= w_csum[CHUNK];
      r_idx   <= w_last ? '0 : r_idx + IW'(1);
      if (w_last) begin
        r_sum  <= {w_csum[CHUNK], w_res};
        r_cout <= w_csum[CHUNK];
        r_ovf  <= w_ovf;
        r_zero <= (w_res == '0);
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;

endmodule

// File: tb/tb_chunked_adder_sub.sv
// tb_chunked_adder_sub: scoreboard bench over four WIDTH/CHUNK configs.
// Expected results come from signed/unsigned integer arithmetic.
module tb_chunked_adder_sub;

  typedef struct {
    logic [32:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    longint      tdone;
  } exp_t;

  localparam int WD[4] = '{32, 8, 8, 8};
  localparam int NC[4] = '{4, 1, 2, 8};

  logic        clk = 1'b0;
  logic        rst_v[4];
  logic        start_v[4];
  logic [31:0] a_v[4];
  logic [31:0] b_v[4];
  logic        cin_v[4];
  logic        sub_v[4];
  logic [3:0]  busy_v, done_v, cout_v, ovf_v, zero_v;
  logic [32:0] sum0;
  logic [8:0]  sum1, sum2, sum3;
  logic [32:0] sum_v[4];

  int     total = 0;
  int     bad = 0;
  longint cyc = 0;
  exp_t   q0[$], q1[$], q2[$], q3[$];
  logic [32:0] last_sum[4];
  logic [3:0]  prev_done = '0;

  assign sum_v[0] = sum0;
  assign sum_v[1] = 33'(sum1);
  assign sum_v[2] = 33'(sum2);
  assign sum_v[3] = 33'(sum3);

  chunked_adder_sub #(.WIDTH(32), .CHUNK(8)) u0 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]),
    .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]), .sub(sub_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum0),
    .cout(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0]));

  chunked_adder_sub #(.WIDTH(8), .CHUNK(8)) u1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]),
    .a(a_v[1][7:0]), .b(b_v[1][7:0]), .cin(cin_v[1]), .sub(sub_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum1),
    .cout(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1]));

  chunked_adder_sub #(.WIDTH(8), .CHUNK(4)) u2 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]),
    .a(a_v[2][7:0]), .b(b_v[2][7:0]), .cin(cin_v[2]), .sub(sub_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum2),
    .cout(cout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2]));

  chunked_adder_sub #(.WIDTH(8), .CHUNK(1)) u3 (
    .clk(clk), .rst(rst_v[3]), .start(start_v[3]),
    .a(a_v[3][7:0]), .b(b_v[3][7:0]), .cin(cin_v[3]), .sub(sub_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .sum(sum3),
    .cout(cout_v[3]), .ovf(ovf_v[3]), .zero(zero_v[3]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(string nm, int d, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0h want=%0h t=%0t", nm, d, act, exp, $time);
    end
  endtask

  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b,
                                 logic cin, logic sub);
    exp_t   e;
    longint m, ua, ub, sa, sb, full, st, res;
    m  = (longint'(1) << w) - 1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    sa = (ua > (m >> 1)) ? ua - (m + 1) : ua;
    sb = (ub > (m >> 1)) ? ub - (m + 1) : ub;
    if (sub) begin
      full   = ua - ub - longint'(cin);
      e.cout = (full >= 0);
      st     = sa - sb - longint'(cin);
    end else begin
      full   = ua + ub + longint'(cin);
      e.cout = ((full >> w) & 1) != 0;
      st     = sa + sb + longint'(cin);
    end
    res    = full & m;
    e.ovf  = (st > (m >> 1)) || (st < -((m + 1) >> 1));
    e.zero = (res == 0);
    e.sum  = 33'((longint'(e.cout) << w) | res);
    e.tdone = 0;
    return e;
  endfunction

  function automatic int qsize(int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic qpush(int d, exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  function automatic exp_t qpop(int d);
    case (d)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  // Monitor: pop and compare on each done, check hold during RUN
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      if (done_v[d]) begin
        if (qsize(d) == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done dut%0d got=1 want=0 t=%0t", d, $time);
        end else begin
          e = qpop(d);
          check("sum", d, 64'(sum_v[d]), 64'(e.sum));
          check("cout", d, 64'(cout_v[d]), 64'(e.cout));
          check("ovf", d, 64'(ovf_v[d]), 64'(e.ovf));
          check("zero", d, 64'(zero_v[d]), 64'(e.zero));
          check("latency", d, 64'(cyc), 64'(e.tdone));
          last_sum[d] = e.sum;
        end
        check("done_pulse", d, 64'(prev_done[d]), 64'(0));
      end else if (busy_v[d]) begin
        check("hold_sum", d, 64'(sum_v[d]), 64'(last_sum[d]));
      end
      prev_done[d] = done_v[d];
    end
  end

  // Call at posedge+1; waits for a free slot, then presents one request
  task automatic issue(int d, logic [31:0] a, logic [31:0] b,
                       logic cin, logic sub);
    int   n = 0;
    exp_t e;
    while (busy_v[d] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy_v[d]) begin
      check("busy_timeout", d, 64'(busy_v[d]), 64'(0));
      return;
    end
    start_v[d] = 1'b1;
    a_v[d] = a;
    b_v[d] = b;
    cin_v[d] = cin;
    sub_v[d] = sub;
    e = model(WD[d], a, b, cin, sub);
    e.tdone = cyc + 1 + longint'(NC[d]);
    qpush(d, e);
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    a_v[d] = $urandom;
    b_v[d] = $urandom;
    cin_v[d] = 1'($urandom);
    sub_v[d] = 1'($urandom);
  endtask

  // Pulse start while RUN; must be ignored
  task automatic junk_start(int d);
    if (!busy_v[d]) return;
    start_v[d] = 1'b1;
    a_v[d] = $urandom;
    b_v[d] = $urandom;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0080;
      3: return 32'h7FFF_FF7F;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    for (int d = 0; d < 4; d++) begin
      rst_v[d] = 1'b1;
      start_v[d] = 1'b1;
      a_v[d] = '1;
      b_v[d] = '1;
      cin_v[d] = 1'b1;
      sub_v[d] = 1'b0;
      last_sum[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      check("rst_busy", d, 64'(busy_v[d]), 64'(0));
      check("rst_done", d, 64'(done_v[d]), 64'(0));
      check("rst_sum", d, 64'(sum_v[d]), 64'(0));
      check("rst_flags", d, 64'({cout_v[d], ovf_v[d], zero_v[d]}), 64'(0));
      rst_v[d] = 1'b0;
      start_v[d] = 1'b0;
    end

    issue(1, 32'h08, 32'h18, 1'b0, 1'b0);
    issue(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    issue(2, 32'h05, 32'h07, 1'b0, 1'b1);
    issue(2, 32'h80, 32'h01, 1'b0, 1'b1);
    issue(3, 32'h7F, 32'h00, 1'b1, 1'b0);
    issue(3, 32'hAA, 32'h55, 1'b1, 1'b0);

    issue(0, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0);
    junk_start(0);
    junk_start(0);
    issue(0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);

    while (busy_v[0] || done_v[0]) begin
      @(posedge clk); #1;
    end
    issue(0, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_v[0] = 1'b1;
    @(posedge clk); #1;
    rst_v[0] = 1'b0;
    void'(qpop(0));
    last_sum[0] = '0;
    check("abort_busy", 0, 64'(busy_v[0]), 64'(0));
    check("abort_done", 0, 64'(done_v[0]), 64'(0));
    check("abort_sum", 0, 64'(sum_v[0]), 64'(0));
    check("abort_cout", 0, 64'(cout_v[0]), 64'(0));
    repeat (10) @(posedge clk);
    #1;
    issue(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      int d;
      d = int'($urandom_range(0, 3));
      issue(d, pick(), pick(), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) junk_start(d);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
    end

    repeat (40) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++)
      check("queue_empty", d, 64'(qsize(d)), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
